// File: rtl/rf_write_arbiter.sv
// Arbitrates the register-file write port between the WB stage and a buffered
// debug/preload port; WB wins, debug drains in idle slots or by a forced stall.
//
// state | meaning
// IDLE  | debug FIFO empty, starvation counter cleared
// WAIT  | debug entries pending; served when WB is idle, counter tracks denials
// STALL | pipeline held; FIFO head written every cycle until the FIFO is empty
module rf_write_arbiter #(
    parameter int XLEN         = 64,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wb_we,
    input  logic [4:0]                    wb_rd,
    input  logic [XLEN-1:0]               wb_data,
    input  logic                          dbg_valid,
    output logic                          dbg_ready,
    input  logic [4:0]                    dbg_rd,
    input  logic [XLEN-1:0]               dbg_data,
    output logic                          rf_we,
    output logic [4:0]                    rf_rd,
    output logic [XLEN-1:0]               rf_wdata,
    output logic                          pipe_stall,
    output logic [$clog2(FIFO_DEPTH):0]   dbg_count,
    output logic                          dbg_x0_drop
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, WAIT, STALL} state_t;

    state_t            state, state_next;
    logic [4:0]        fifo_rd   [FIFO_DEPTH];
    logic [XLEN-1:0]   fifo_data [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count, count_next;
    logic [7:0]        starve_cnt, starve_next;
    logic              wb_req, push, pop, grant_dbg, grant_wb;
    logic [4:0]        head_rd;
    logic [XLEN-1:0]   head_data;

    assign wb_req    = wb_we && (wb_rd != 5'd0);
    assign push      = dbg_valid && dbg_ready;
    assign head_rd   = fifo_rd[rd_ptr];
    assign head_data = fifo_data[rd_ptr];
    assign dbg_count = count;

    always_comb begin
        state_next  = state;
        starve_next = starve_cnt;
        pop         = 1'b0;
        grant_dbg   = 1'b0;
        grant_wb    = 1'b0;
        count_next  = count;
        case (state)
            IDLE: begin
                grant_wb = wb_req;
                if (push) state_next = WAIT;
            end
            WAIT: begin
                if (wb_req) begin
                    grant_wb    = 1'b1;
                    starve_next = (starve_cnt >= LIMIT) ? LIMIT : starve_cnt + 8'd1;
                    if (starve_next == LIMIT) state_next = STALL;
                end else begin
                    grant_dbg   = 1'b1;
                    pop         = 1'b1;
                    starve_next = 8'd0;
                end
            end
            STALL: begin
                grant_dbg   = 1'b1;
                pop         = 1'b1;
                starve_next = 8'd0;
            end
            default: state_next = IDLE;
        endcase
        count_next = count + CW'(push) - CW'(pop);
        if (pop && count_next == '0) state_next = IDLE;
    end

    // A popped x0 entry consumes its slot but never reaches the register file.
    always_comb begin
        rf_we    = 1'b0;
        rf_rd    = 5'd0;
        rf_wdata = '0;
        if (reset) begin
            if (grant_dbg) begin
                if (head_rd != 5'd0) begin
                    rf_we    = 1'b1;
                    rf_rd    = head_rd;
                    rf_wdata = head_data;
                end
            end else if (grant_wb) begin
                rf_we    = 1'b1;
                rf_rd    = wb_rd;
                rf_wdata = wb_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            starve_cnt  <= 8'd0;
            dbg_ready   <= 1'b0;
            pipe_stall  <= 1'b0;
            dbg_x0_drop <= 1'b0;
        end else begin
            state       <= state_next;
            count       <= count_next;
            starve_cnt  <= starve_next;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            dbg_ready   <= (count_next < CW'(FIFO_DEPTH)) && (state_next != STALL);
            pipe_stall  <= (state_next == STALL);
            dbg_x0_drop <= pop && (head_rd == 5'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr]   <= dbg_rd;
            fifo_data[wr_ptr] <= dbg_data;
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: scoreboard of expected debug writes checked by a
// negedge monitor, plus per-scenario inline checks.
module tb_rf_write_arbiter;

    localparam int XLEN         = 64;
    localparam int FIFO_DEPTH   = 2;
    localparam int STARVE_LIMIT = 8;

    logic                        clk, reset;
    logic                        wb_we, dbg_valid, dbg_ready;
    logic [4:0]                  wb_rd, dbg_rd, rf_rd;
    logic [XLEN-1:0]             wb_data, dbg_data, rf_wdata;
    logic                        rf_we, pipe_stall, dbg_x0_drop;
    logic [$clog2(FIFO_DEPTH):0] dbg_count;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wr_t;

    wr_t             sb[$];
    wr_t             mon_e;
    logic [XLEN-1:0] model [32];
    int              vectors = 0;
    int              miscompares = 0;

    rf_write_arbiter #(.XLEN(XLEN), .FIFO_DEPTH(FIFO_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .reset(reset),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_rd(dbg_rd), .dbg_data(dbg_data),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
        .pipe_stall(pipe_stall), .dbg_count(dbg_count), .dbg_x0_drop(dbg_x0_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: WB must own the port whenever it requests and no stall is held;
    // any other write must be the oldest outstanding debug write.
    always @(negedge clk) begin
        if (!reset) begin
            sb.delete();
            for (int i = 0; i < 32; i++) model[i] = '0;
        end else begin
            if (!pipe_stall && wb_we && wb_rd != 5'd0) begin
                vectors++;
                if ({rf_we, rf_rd, rf_wdata} !== {1'b1, wb_rd, wb_data}) begin
                    miscompares++;
                    $display("FAIL wb_grant: got we/rd/data=%0b/%0d/%0h, expected 1/%0d/%0h",
                             rf_we, rf_rd, rf_wdata, wb_rd, wb_data);
                end
            end else if (rf_we) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL dbg_grant: got write rd=%0d data=%0h, expected no write", rf_rd, rf_wdata);
                end else begin
                    mon_e = sb.pop_front();
                    if (rf_rd !== mon_e.rd || rf_wdata !== mon_e.data) begin
                        miscompares++;
                        $display("FAIL dbg_grant: got rd=%0d data=%0h, expected rd=%0d data=%0h",
                                 rf_rd, rf_wdata, mon_e.rd, mon_e.data);
                    end
                end
            end
            vectors++;
            if (rf_we === 1'b1 && rf_rd === 5'd0) begin
                miscompares++;
                $display("FAIL x0_write: got rf_we=1 rd=0, expected no write to x0");
            end
            if (rf_we === 1'b1) model[rf_rd] = rf_wdata;
            vectors++;
            if (dbg_count > FIFO_DEPTH) begin
                miscompares++;
                $display("FAIL count_bound: got dbg_count=%0d, expected <= %0d", dbg_count, FIFO_DEPTH);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [4:0] rd, input logic [XLEN-1:0] data,
                         input int budget, output int waited);
        wr_t  e;
        logic acc;
        dbg_valid = 1'b1;
        dbg_rd    = rd;
        dbg_data  = data;
        waited    = 0;
        acc       = 1'b0;
        while (!acc && waited < budget) begin
            @(negedge clk);
            acc = dbg_ready;
            if (acc && rd != 5'd0) begin
                e.rd   = rd;
                e.data = data;
                sb.push_back(e);
            end
            @(posedge clk);
            #1;
            if (!acc) waited++;
        end
        dbg_valid = 1'b0;
        vectors++;
        if (!acc) begin
            miscompares++;
            $display("FAIL offer_timeout: rd=%0d not accepted, expected within %0d cycles", rd, budget);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (!(sb.size() == 0 && dbg_count == 0 && !pipe_stall) && n < budget) begin
            step();
            n++;
        end
        vectors++;
        if (n >= budget) begin
            miscompares++;
            $display("FAIL drain_timeout: got pending=%0d count=%0d stall=%0b, expected drained in %0d cycles",
                     sb.size(), dbg_count, pipe_stall, budget);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; dbg_valid = 1'b0; dbg_rd = '0; dbg_data = '0;
        wb_we = 1'b1; wb_rd = 5'd6; wb_data = 64'h66;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({pipe_stall, dbg_x0_drop, dbg_ready, rf_we} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_flags: got stall/drop/ready/we=%b, expected 0000",
                     {pipe_stall, dbg_x0_drop, dbg_ready, rf_we});
        end
        vectors++;
        if (dbg_count !== '0 || rf_rd !== 5'd0 || rf_wdata !== '0) begin
            miscompares++;
            $display("FAIL reset_values: got count=%0d rd=%0d data=%0h, expected 0/0/0", dbg_count, rf_rd, rf_wdata);
        end
        wb_we = 1'b0;
        reset = 1'b1;
        step();
        vectors++;
        if (dbg_ready !== 1'b1 || dbg_count !== '0 || pipe_stall !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: got ready=%b count=%0d stall=%b, expected 1/0/0", dbg_ready, dbg_count, pipe_stall);
        end
    endtask

    task automatic test_idle_drain();
        int w;
        wb_we = 1'b0;
        offer(5'd5, 64'd5, 10, w);
        vectors++;
        if (rf_we !== 1'b1 || rf_rd !== 5'd5 || rf_wdata !== 64'd5) begin
            miscompares++;
            $display("FAIL idle_first: got we/rd/data=%b/%0d/%0h, expected 1/5/5", rf_we, rf_rd, rf_wdata);
        end
        offer(5'd7, 64'd7, 10, w);
        vectors++;
        if (rf_we !== 1'b1 || rf_rd !== 5'd7 || rf_wdata !== 64'd7 || dbg_count !== 1) begin
            miscompares++;
            $display("FAIL idle_second: got we/rd/data/count=%b/%0d/%0h/%0d, expected 1/7/7/1",
                     rf_we, rf_rd, rf_wdata, dbg_count);
        end
        step();
        vectors++;
        if (rf_we !== 1'b0 || dbg_count !== 0 || pipe_stall !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_done: got we/count/stall=%b/%0d/%b, expected 0/0/0", rf_we, dbg_count, pipe_stall);
        end
    endtask

    task automatic test_wb_priority();
        int w;
        wb_we = 1'b1; wb_rd = 5'd3; wb_data = -64'sd3;
        offer(5'd9, 64'd9, 10, w);
        for (int i = 0; i < STARVE_LIMIT; i++) begin
            vectors++;
            if (pipe_stall !== 1'b0 || rf_rd !== 5'd3) begin
                miscompares++;
                $display("FAIL prio_wb_cycle%0d: got stall=%b rd=%0d, expected 0/3", i, pipe_stall, rf_rd);
            end
            step();
        end
        vectors++;
        if (pipe_stall !== 1'b1 || rf_we !== 1'b1 || rf_rd !== 5'd9 || rf_wdata !== 64'd9) begin
            miscompares++;
            $display("FAIL prio_stall: got stall/we/rd/data=%b/%b/%0d/%0h, expected 1/1/9/9",
                     pipe_stall, rf_we, rf_rd, rf_wdata);
        end
        step();
        vectors++;
        if (pipe_stall !== 1'b0 || rf_rd !== 5'd3 || dbg_count !== 0 || dbg_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL prio_release: got stall/rd/count/ready=%b/%0d/%0d/%b, expected 0/3/0/1",
                     pipe_stall, rf_rd, dbg_count, dbg_ready);
        end
        wb_we = 1'b0;
    endtask

    task automatic test_full_fifo();
        int w;
        wb_we = 1'b1; wb_rd = 5'd4; wb_data = 64'h44;
        offer(5'd10, 64'ha, 10, w);
        offer(5'd11, 64'hb, 10, w);
        vectors++;
        if (dbg_ready !== 1'b0 || dbg_count !== 2) begin
            miscompares++;
            $display("FAIL full_accepts: got ready=%b count=%0d, expected 0/2", dbg_ready, dbg_count);
        end
        offer(5'd12, 64'hc, 40, w);
        // Held through STARVE_LIMIT-1 more WB cycles plus a stall draining both entries.
        vectors++;
        if (w != STARVE_LIMIT + FIFO_DEPTH - 1) begin
            miscompares++;
            $display("FAIL full_held: got wait=%0d cycles, expected %0d", w, STARVE_LIMIT + FIFO_DEPTH - 1);
        end
        vectors++;
        if (dbg_count !== 1) begin
            miscompares++;
            $display("FAIL full_third: got count=%0d, expected 1", dbg_count);
        end
        wait_idle(60);
        wb_we = 1'b0;
    endtask

    task automatic test_x0();
        int w;
        wb_we = 1'b0;
        offer(5'd0, 64'h100, 10, w);
        vectors++;
        if (rf_we !== 1'b0 || dbg_x0_drop !== 1'b0) begin
            miscompares++;
            $display("FAIL x0_pop: got we=%b drop=%b, expected 0/0", rf_we, dbg_x0_drop);
        end
        step();
        vectors++;
        if (dbg_x0_drop !== 1'b1 || dbg_count !== 0) begin
            miscompares++;
            $display("FAIL x0_pulse: got drop=%b count=%0d, expected 1/0", dbg_x0_drop, dbg_count);
        end
        step();
        vectors++;
        if (dbg_x0_drop !== 1'b0) begin
            miscompares++;
            $display("FAIL x0_pulse_end: got drop=%b, expected 0", dbg_x0_drop);
        end
        wb_we = 1'b1; wb_rd = 5'd0; wb_data = 64'h55;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (rf_we !== 1'b0) begin
                miscompares++;
                $display("FAIL x0_wb%0d: got rf_we=%b, expected 0", i, rf_we);
            end
            step();
        end
        wb_we = 1'b0;
        vectors++;
        if (model[0] !== '0) begin
            miscompares++;
            $display("FAIL x0_value: got x0=%0h, expected 0", model[0]);
        end
    endtask

    task automatic test_reset_mid_stall();
        int w;
        int n = 0;
        wb_we = 1'b1; wb_rd = 5'd2; wb_data = 64'h22;
        offer(5'd13, 64'hd, 10, w);
        offer(5'd14, 64'he, 10, w);
        while (!pipe_stall && n < 20) begin
            step();
            n++;
        end
        vectors++;
        if (pipe_stall !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_reach_stall: got stall=%b, expected 1 within 20 cycles", pipe_stall);
        end
        #2 reset = 1'b0;
        #1;
        vectors++;
        if (pipe_stall !== 1'b0 || dbg_count !== 0 || dbg_ready !== 1'b0 || rf_we !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_async: got stall/count/ready/we=%b/%0d/%b/%b, expected 0/0/0/0",
                     pipe_stall, dbg_count, dbg_ready, rf_we);
        end
        wb_we = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        step();
        vectors++;
        if (dbg_ready !== 1'b1 || pipe_stall !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_release: got ready=%b stall=%b, expected 1/0", dbg_ready, pipe_stall);
        end
    endtask

    task automatic test_integration();
        logic [XLEN-1:0] golden [32];
        wr_t  e;
        logic acc, held;
        int   n_dbg = 0;
        int   cyc = 0;
        int   n = 0;
        for (int i = 0; i < 32; i++) golden[i] = '0;
        dbg_valid = 1'b0; wb_we = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        step();
        while (cyc < 400 && !(n_dbg == 4 && cyc >= 60)) begin
            @(negedge clk);
            acc  = dbg_valid && dbg_ready;
            held = pipe_stall;
            if (acc) begin
                e.rd = dbg_rd; e.data = dbg_data;
                sb.push_back(e);
                golden[dbg_rd] = dbg_data;
            end
            @(posedge clk);
            #1;
            if (acc) begin
                n_dbg++;
                dbg_valid = 1'b0;
            end
            if (!dbg_valid && n_dbg < 4 && $urandom_range(0, 3) == 0) begin
                dbg_valid = 1'b1;
                dbg_rd    = 5'(20 + n_dbg);
                dbg_data  = 64'hD000 + 64'(n_dbg);
            end
            if (!held) begin
                wb_we   = ($urandom_range(0, 9) < 7);
                wb_rd   = 5'($urandom_range(0, 15));
                wb_data = {$urandom, $urandom};
                if (wb_we && wb_rd != 5'd0) golden[wb_rd] = wb_data;
            end
            cyc++;
        end
        dbg_valid = 1'b0;
        while (pipe_stall && n < 20) begin
            step();
            n++;
        end
        step();
        wb_we = 1'b0;
        wait_idle(80);
        vectors++;
        if (n_dbg != 4) begin
            miscompares++;
            $display("FAIL integ_dbg_count: got %0d debug writes accepted, expected 4", n_dbg);
        end
        for (int r = 0; r < 32; r++) begin
            vectors++;
            if (model[r] !== golden[r]) begin
                miscompares++;
                $display("FAIL integ_x%0d: got %0h, expected %0h", r, model[r], golden[r]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle_drain();
        test_wb_priority();
        test_full_fifo();
        test_x0();
        test_reset_mid_stall();
        test_integration();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL sb_empty: got %0d debug writes never seen, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 500000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
